// File: rtl/dp_mem_responder_if.sv
// Datapath/cache bus bundle: fetch, data access and backing-RAM signals.
// The responder takes the slave view; datapath plus RAM take the master view.
interface dp_mem_responder_if;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic [31:0] imiss_count;

    modport slave (
        input  halt, imemREN, imemaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ram_ready,
        output imemload, ihit, dmemload, dhit,
        output ramREN, ramWEN, ramaddr, ramstore,
        output imiss_count
    );

    modport master (
        output halt, imemREN, imemaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ram_ready,
        input  imemload, ihit, dmemload, dhit,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  imiss_count
    );
endinterface

// File: rtl/dp_mem_responder.sv
// Datapath responder: direct-mapped one-word icache plus pass-through
// data port sharing a single backing RAM; data accesses win over fills.
module dp_mem_responder #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input logic CLK,
    input logic RST,
    dp_mem_responder_if.slave bus
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX - 2;

    typedef enum logic [1:0] {IDLE, DACC, DDONE, IFILL} state_t;

    state_t state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    logic [31:0]      lines [SETS];

    logic             dreq;
    logic [IDX-1:0]   i_idx;
    logic [TAG_W-1:0] i_tag;
    logic             i_match;
    logic [IDX-1:0]   r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_match;
    logic             fill_done;
    logic             store_hit;
    logic             line_we;
    logic [31:0]      line_wdata;
    logic             unused_addr_bits;

    assign dreq = bus.dmemREN | bus.dmemWEN;

    // Fetch-side lookup
    assign i_idx   = bus.imemaddr[IDX+1:2];
    assign i_tag   = bus.imemaddr[ADDR_W-1:IDX+2];
    assign i_match = valid[i_idx] && (tags[i_idx] == i_tag);

    assign bus.ihit = (state == IDLE) && bus.imemREN && !bus.halt
                      && !dreq && i_match;
    assign bus.imemload = i_match ? lines[i_idx] : '0;

    // The registered RAM address doubles as the latched access address
    assign r_idx   = bus.ramaddr[IDX+1:2];
    assign r_tag   = bus.ramaddr[ADDR_W-1:IDX+2];
    assign r_match = valid[r_idx] && (tags[r_idx] == r_tag);

    assign fill_done  = (state == IFILL) && bus.ram_ready;
    assign store_hit  = (state == DACC) && bus.ram_ready
                        && bus.ramWEN && r_match;
    assign line_we    = fill_done || store_hit;
    assign line_wdata = fill_done ? bus.ramload : bus.ramstore;

    assign unused_addr_bits = ^bus.imemaddr[1:0];

    // Line tag/data storage: fills and coherent store updates
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tags[r_idx]  <= r_tag;
            lines[r_idx] <= line_wdata;
        end
    end

    // Control FSM with registered RAM request, dhit and load data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            valid           <= '0;
            bus.dhit        <= 1'b0;
            bus.dmemload    <= '0;
            bus.imiss_count <= '0;
            bus.ramREN      <= 1'b0;
            bus.ramWEN      <= 1'b0;
            bus.ramaddr     <= '0;
            bus.ramstore    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq) begin
                        state        <= DACC;
                        bus.ramaddr  <= bus.dmemaddr;
                        bus.ramstore <= bus.dmemstore;
                        bus.ramREN   <= !bus.dmemWEN;
                        bus.ramWEN   <= bus.dmemWEN;
                    end else if (bus.imemREN && !bus.halt && !i_match) begin
                        state           <= IFILL;
                        bus.ramaddr     <= bus.imemaddr;
                        bus.ramREN      <= 1'b1;
                        bus.ramWEN      <= 1'b0;
                        bus.imiss_count <= bus.imiss_count + 32'd1;
                    end
                end
                DACC: begin
                    if (bus.ram_ready) begin
                        if (!bus.ramWEN) begin
                            bus.dmemload <= bus.ramload;
                        end
                        bus.ramREN <= 1'b0;
                        bus.ramWEN <= 1'b0;
                        bus.dhit   <= 1'b1;
                        state      <= DDONE;
                    end
                end
                DDONE: begin
                    bus.dhit <= 1'b0;
                    state    <= IDLE;
                end
                IFILL: begin
                    if (bus.ram_ready) begin
                        valid[r_idx] <= 1'b1;
                        bus.ramREN   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_mem_responder.sv
// Scoreboard bench for dp_mem_responder: directed fetch/load/store
// vectors, a latency-programmable RAM model and a response monitor.
module tb_dp_mem_responder;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    dp_mem_responder_if bus ();

    dp_mem_responder #(.SETS(16), .ADDR_W(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          ram_lat = 3;
    int          ram_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // RAM model: completes a request after ram_lat request cycles
    always @(negedge CLK) begin
        if (RST || !(bus.ramREN || bus.ramWEN)) begin
            bus.ram_ready = 1'b0;
            ram_cnt = 0;
        end else if (bus.ram_ready) begin
            bus.ram_ready = 1'b0;
            ram_cnt = 0;
        end else begin
            ram_cnt++;
            if (ram_cnt == ram_lat) begin
                bus.ram_ready = 1'b1;
                if (bus.ramWEN)
                    mem[bus.ramaddr] = bus.ramstore;
                else
                    bus.ramload = mem.exists(bus.ramaddr) ? mem[bus.ramaddr] : 32'h0;
            end
        end
    end

    // Monitor: pops the scoreboard on each ihit/dhit
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (bus.ihit && bus.dhit) chk("ihit_dhit_overlap", 1, 0);
            if (bus.dhit) begin
                if (exp_q.size() == 0) chk("unexpected_dhit", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_dhit_kind", 1, {31'd0, e.is_d});
                    if (e.chk_data) chk("sb_dmemload", bus.dmemload, e.data);
                end
            end
            if (bus.ihit) begin
                if (exp_q.size() == 0) chk("unexpected_ihit", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_ihit_kind", 0, {31'd0, e.is_d});
                    chk("sb_imemload", bus.imemload, e.data);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input int e_lat, input int e_ram,
                         input logic [31:0] e_cnt);
        int lat = 0;
        int rc = 0;
        bit got = 0;
        bit badaddr = 0;
        exp_q.push_back('{1'b0, 1'b1, d});
        bus.imemREN = 1'b1;
        bus.imemaddr = a;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge CLK);
            if (bus.ihit) got = 1;
            else begin
                lat++;
                if (bus.ramREN) begin
                    rc++;
                    if (bus.ramaddr !== a) badaddr = 1;
                end
            end
        end
        @(posedge CLK);
        #1 bus.imemREN = 1'b0;
        chk("fetch_done", {31'd0, got}, 1);
        chk("fetch_latency", lat, e_lat);
        chk("fetch_ram_cycles", rc, e_ram);
        chk("fetch_ramaddr", {31'd0, badaddr}, 0);
        chk("imiss_count", bus.imiss_count, e_cnt);
    endtask

    task automatic dacc(input bit ren, input bit wen, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] e_load);
        int rc = 0;
        bit got = 0;
        bit badreq = 0;
        exp_q.push_back('{1'b1, !wen, e_load});
        bus.dmemREN = ren;
        bus.dmemWEN = wen;
        bus.dmemaddr = a;
        bus.dmemstore = sd;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge CLK);
            if (bus.dhit) got = 1;
            else if (bus.ramREN || bus.ramWEN) begin
                rc++;
                if (bus.ramaddr !== a || bus.ramWEN !== wen
                    || bus.ramREN !== !wen) badreq = 1;
                if (wen && bus.ramstore !== sd) badreq = 1;
            end
        end
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        chk("dacc_done", {31'd0, got}, 1);
        chk("dacc_ram_cycles", rc, ram_lat);
        chk("dacc_ram_req", {31'd0, badreq}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end

    initial begin
        int dcnt;
        int n40;
        int n200;
        int nother;
        int hits;
        bit gotd;
        bit goti;
        bit early;
        logic [31:0] first_addr;

        mem[32'h40]  = 32'h2001_0005;
        mem[32'h80]  = 32'hAAAA_0080;
        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h44]  = 32'h0044_4444;
        mem[32'h200] = 32'h0200_0200;

        bus.halt = 0; bus.imemREN = 0; bus.imemaddr = 0;
        bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0;
        bus.dmemstore = 0; bus.ramload = 0; bus.ram_ready = 0;

        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dhit", {31'd0, bus.dhit}, 0);
        chk("rst_dmemload", bus.dmemload, 0);
        chk("rst_imiss", bus.imiss_count, 0);
        chk("rst_ramREN", {31'd0, bus.ramREN}, 0);
        chk("rst_ramWEN", {31'd0, bus.ramWEN}, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // cold fetch, then hit with no RAM activity
        fetch(32'h40, 32'h2001_0005, 4, 3, 1);
        fetch(32'h40, 32'h2001_0005, 0, 0, 1);

        // conflict misses on index 0
        fetch(32'h80, 32'hAAAA_0080, 4, 3, 2);
        fetch(32'h40, 32'h2001_0005, 4, 3, 3);

        // data load and icache miss in the same cycle
        exp_q.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
        exp_q.push_back('{1'b0, 1'b1, 32'h0044_4444});
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h44;
        dcnt = 0; gotd = 0; goti = 0; early = 0; first_addr = 32'hFFFF_FFFF;
        for (int c = 0; c < 60 && !goti; c++) begin
            @(negedge CLK);
            if ((bus.ramREN || bus.ramWEN) && first_addr === 32'hFFFF_FFFF)
                first_addr = bus.ramaddr;
            if (bus.ihit) begin
                goti = 1;
                if (!gotd) early = 1;
            end
            if (bus.dhit) begin
                dcnt++;
                gotd = 1;
                @(posedge CLK);
                #1 bus.dmemREN = 1'b0;
            end
        end
        @(posedge CLK);
        #1 bus.imemREN = 1'b0;
        chk("prio_first_ramaddr", first_addr, 32'h100);
        chk("prio_dhit_pulses", dcnt, 1);
        chk("prio_ihit_seen", {31'd0, goti}, 1);
        chk("prio_ihit_early", {31'd0, early}, 0);
        chk("prio_imiss", bus.imiss_count, 4);

        // store (REN and WEN both high) onto a cached line
        dacc(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h0);
        fetch(32'h40, 32'h1234_5678, 0, 0, 4);
        dacc(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678);

        // redirect during a fill
        fetch(32'h80, 32'hAAAA_0080, 4, 3, 5);
        exp_q.push_back('{1'b0, 1'b1, 32'h0200_0200});
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        @(posedge CLK);
        #1 bus.imemaddr = 32'h200;
        n40 = 0; n200 = 0; nother = 0; goti = 0;
        for (int c = 0; c < 60 && !goti; c++) begin
            @(negedge CLK);
            if (bus.ihit) goti = 1;
            else if (bus.ramREN) begin
                if (bus.ramaddr === 32'h40) n40++;
                else if (bus.ramaddr === 32'h200) n200++;
                else nother++;
            end
        end
        @(posedge CLK);
        #1 bus.imemREN = 1'b0;
        chk("redir_ihit", {31'd0, goti}, 1);
        chk("redir_fill40_cycles", n40, 3);
        chk("redir_fill200_cycles", n200, 3);
        chk("redir_other_addr", nother, 0);
        chk("redir_imiss", bus.imiss_count, 7);

        // halt blocks hits and new fills
        bus.halt = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h200;
        hits = 0; n40 = 0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.ihit) hits++;
        end
        bus.imemaddr = 32'h48;
        repeat (3) begin
            @(negedge CLK);
            if (bus.ihit) hits++;
            if (bus.ramREN) n40++;
        end
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b0; bus.halt = 1'b0;
        chk("halt_ihit", hits, 0);
        chk("halt_ram_cycles", n40, 0);
        chk("halt_imiss", bus.imiss_count, 7);

        // reset during a data access
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        goti = 0;
        for (int c = 0; c < 20 && !goti; c++) begin
            @(negedge CLK);
            if (bus.ramREN) goti = 1;
        end
        chk("rst_dacc_entered", {31'd0, goti}, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_ramREN", {31'd0, bus.ramREN}, 0);
        chk("mid_rst_ramaddr", bus.ramaddr, 0);
        chk("mid_rst_dmemload", bus.dmemload, 0);
        chk("mid_rst_imiss", bus.imiss_count, 0);
        chk("mid_rst_dhit", {31'd0, bus.dhit}, 0);
        bus.dmemREN = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        fetch(32'h40, 32'h1234_5678, 4, 3, 1);

        repeat (2) @(posedge CLK);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
